top_bus_initiator: RTL
======================

Name: top_bus_initiator

Overview:
- Microcontroller-side master for the bottomhalf register bus: ALE address latch, write strobe, read strobe, and a shared 8-bit data bus.
- Converts single register commands (write addr/data, read addr) into correctly timed bus cycles.
- Returns read data on a response strobe.
- Used in FPGA self-test/loopback builds and as the bus driver in on-chip bench harnesses for bottomhalf layouts.

Parameters:
- T_ALE, 2, cycles ALE held high with address driven (1..15)
- T_HOLD, 1, cycles of address/data hold and bus turnaround (1..15)
- T_SETUP, 1, cycles write data driven before write rises (1..15)
- T_STROBE, 3, cycles write held high, or read held low (1..15)

Ports:
- osc  in  1  system clock; all logic on posedge
- rst  in  1  synchronous reset, active high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = register write, 0 = register read
- cmd_addr  in  8  register address
- cmd_wdata  in  8  write data
- cache_flush  in  1  invalidates the cached address
- rsp_valid  out  1  one-cycle pulse carrying read data
- rsp_data  out  8  read result; held until next read
- bus_ale  out  1  idle 0; slave latches address on falling edge
- bus_write  out  1  idle 0; slave samples data on rising edge
- bus_read  out  1  idle 1; active low, slave drives data while low
- bus_data_out  out  8  driven value
- bus_data_oe  out  1  1 = master drives the data bus
- bus_data_in  in  8  sampled bus value

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, bus_ale=0, bus_write=0, bus_read=1, bus_data_out=0, bus_data_oe=0, state=IDLE, addr_cached=0, addr_valid=0.
- Accept: cmd_valid&&cmd_ready on edge N. FSM leaves IDLE at N+1 and latches addr, wdata and write.
- Address skip: if addr_valid && cmd_addr==addr_cached, ALE_HI and ALE_LO are skipped.
  - Write goes directly to WR_SETUP.
  - Read goes directly to TURN.
- ALE_HI (T_ALE): ale=1, oe=1, data_out=addr.
- ALE_LO (T_HOLD): ale=0, data held at addr. On exit: addr_cached=addr, addr_valid=1.
- Write path:
  - WR_SETUP (T_SETUP): data_out=wdata, oe=1.
  - WR_HI (T_STROBE): write=1.
  - WR_LO (T_HOLD): write=0, data held.
  - Then IDLE with oe=0.
- Read path:
  - TURN (T_HOLD): oe=0.
  - RD_LO (T_STROBE): read=0. bus_data_in is captured on the last cycle of RD_LO.
  - RD_HI (T_HOLD): read=1. rsp_valid=1 in the first RD_HI cycle only; rsp_data updated in the same cycle.
  - Then IDLE.
- Default latency, new address: write 8 cycles, read 8 cycles (ALE 3 + 5). Cached address: 5 cycles each. cmd_ready stays low for the whole command.
- bus_ale, bus_write and bus_read are registered outputs. They are never active in the same cycle, and bus_write and bus_read never toggle while bus_ale=1.
- oe is never 1 during RD_LO or TURN. oe is 0 in IDLE.
- cache_flush:
  - in IDLE, clears addr_valid that cycle;
  - during a command, clears addr_valid at command end, overriding the ALE_LO set;
  - when asserted together with a command accept, the flush applies first and the ALE is issued.
- Phase counter: 4 bits, loaded with T-1 on phase entry; the phase exits when the counter reads 0.
- Reset mid-command: on the next edge all outputs return to their reset values, the command is dropped, no rsp_valid is issued, and the cache is invalidated.
- cmd_* inputs are ignored outside IDLE.

Decomposition:
- Package top_bus_pkg holds:
  - the state enum (IDLE, ALE_HI, ALE_LO, WR_SETUP, WR_HI, WR_LO, TURN, RD_LO, RD_HI);
  - the default timing constants;
  - the register addresses ID_LO=8'hFD, ID_HI=8'hFE, REV=8'hFF.
- One sub-module, top_bus_phase_timer: load value, load strobe, decrement, done flag.

Test Plan:
- Write 0x10<-0xA5 after reset: ale high for cycles 1-2; write rises at cycle 5 with data_out=0xA5 and oe=1; cmd_ready returns at cycle 9.
- Second write 0x10<-0x3C: no ALE pulse; write rises 2 cycles after accept; total 5 cycles.
- Read 0xFD with bus_data_in=0x0C during RD_LO: rsp_valid single pulse, rsp_data=0x0C; oe=0 throughout TURN/RD_LO; total 8 cycles.
- cache_flush, then write 0x10: ALE re-issued with data_out=0x10.
- rst asserted in WR_HI: next cycle write=0, oe=0, cmd_ready=1; next command to the same address issues ALE.
- cmd_valid held high continuously with alternating read and write commands: every command is accepted exactly once, and strobes never overlap.

Source files
------------

// File: rtl/top_bus_pkg.sv
// Shared types and constants for the bottomhalf register-bus initiator.
package top_bus_pkg;

   // Bus-cycle phases of the initiator FSM.
   typedef enum logic [3:0] {
      IDLE,
      ALE_HI,
      ALE_LO,
      WR_SETUP,
      WR_HI,
      WR_LO,
      TURN,
      RD_LO,
      RD_HI
   } state_t;

   // Default phase lengths in clock cycles (legal range 1..15).
   localparam int unsigned T_ALE_DEF    = 2;
   localparam int unsigned T_HOLD_DEF   = 1;
   localparam int unsigned T_SETUP_DEF  = 1;
   localparam int unsigned T_STROBE_DEF = 3;

   // Well-known bottomhalf register addresses.
   localparam logic [7:0] ID_LO = 8'hFD;
   localparam logic [7:0] ID_HI = 8'hFE;
   localparam logic [7:0] REV   = 8'hFF;

   // A phase of length t is loaded as t-1 so it ends when the counter reads 0.
   function automatic logic [3:0] phase_load(input int unsigned t);
      return 4'(t - 1);
   endfunction

endpackage

// File: rtl/top_bus_initiator_if.sv
// Command/response handshake plus the bottomhalf bus pins of the initiator.
interface top_bus_initiator_if;

   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_write;
   logic [7:0] cmd_addr;
   logic [7:0] cmd_wdata;
   logic       cache_flush;
   logic       rsp_valid;
   logic [7:0] rsp_data;
   logic       bus_ale;
   logic       bus_write;
   logic       bus_read;
   logic [7:0] bus_data_out;
   logic       bus_data_oe;
   logic [7:0] bus_data_in;

   // Initiator view: takes commands, drives the bus strobes and data.
   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cache_flush, bus_data_in,
      output cmd_ready, rsp_valid, rsp_data,
             bus_ale, bus_write, bus_read, bus_data_out, bus_data_oe
   );

   // Command source / bus slave view.
   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cache_flush, bus_data_in,
      input  cmd_ready, rsp_valid, rsp_data,
             bus_ale, bus_write, bus_read, bus_data_out, bus_data_oe
   );

endinterface

// File: rtl/top_bus_phase_timer.sv
// Down-counter timing one bus phase: load T-1 on entry, done when it reads 0.
module top_bus_phase_timer (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       done
);

   logic [3:0] count;

   // Load on phase entry, otherwise count down towards zero and stop there.
   always_ff @(posedge clk) begin
      // NOTE: registers are updated with <= so every flop samples pre-edge values.
      if (rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != '0)) begin
         count <= count - 4'd1;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/top_bus_initiator.sv
// Bottomhalf register-bus master: turns single read/write commands into
// ALE / write-strobe / read-strobe bus cycles, skipping ALE on a repeated address.
module top_bus_initiator
   import top_bus_pkg::*;
#(
   parameter int unsigned T_ALE    = T_ALE_DEF,
   parameter int unsigned T_HOLD   = T_HOLD_DEF,
   parameter int unsigned T_SETUP  = T_SETUP_DEF,
   parameter int unsigned T_STROBE = T_STROBE_DEF
) (
   input logic                 osc,
   input logic                 rst,
   top_bus_initiator_if.master bus
);

   state_t     state;
   state_t     next_state;
   logic [7:0] addr_q;
   logic [7:0] wdata_q;
   logic       write_q;
   logic [7:0] addr_cached;
   logic       addr_valid;
   logic       flush_pending;

   logic       accept;
   logic       addr_hit;
   logic       timer_done;
   logic       timer_load;
   logic [3:0] timer_val;
   logic [7:0] cur_addr;
   logic [7:0] cur_wdata;

   // Commands are only taken in IDLE, which is exactly when cmd_ready is high.
   assign accept = (state == IDLE) && bus.cmd_valid;

   // A flush arriving with the command wins, so the address phase is re-issued.
   assign addr_hit = addr_valid && !bus.cache_flush && (bus.cmd_addr == addr_cached);

   // On the accept edge the command fields are not latched yet, so use them directly.
   assign cur_addr  = accept ? bus.cmd_addr  : addr_q;
   assign cur_wdata = accept ? bus.cmd_wdata : wdata_q;

   // Next-phase decision; each phase ends when the phase timer reads zero.
   always_comb begin
      // NOTE: next_state gets a default first so no path leaves it unassigned (no latch).
      next_state = state;
      unique case (state)
         IDLE:     if (accept)
                      next_state = addr_hit ? (bus.cmd_write ? WR_SETUP : TURN) : ALE_HI;
         ALE_HI:   if (timer_done) next_state = ALE_LO;
         ALE_LO:   if (timer_done) next_state = write_q ? WR_SETUP : TURN;
         WR_SETUP: if (timer_done) next_state = WR_HI;
         WR_HI:    if (timer_done) next_state = WR_LO;
         WR_LO:    if (timer_done) next_state = IDLE;
         TURN:     if (timer_done) next_state = RD_LO;
         RD_LO:    if (timer_done) next_state = RD_HI;
         RD_HI:    if (timer_done) next_state = IDLE;
         default:  next_state = IDLE;
      endcase
   end

   // Reload the phase timer with the length of whichever phase is being entered.
   always_comb begin
      timer_load = (next_state != state) && (next_state != IDLE);
      timer_val  = '0;
      case (next_state)
         ALE_HI:                     timer_val = phase_load(T_ALE);
         ALE_LO, WR_LO, TURN, RD_HI: timer_val = phase_load(T_HOLD);
         WR_SETUP:                   timer_val = phase_load(T_SETUP);
         WR_HI, RD_LO:               timer_val = phase_load(T_STROBE);
         default:                    timer_val = '0;
      endcase
   end

   top_bus_phase_timer u_timer (
      .clk      (osc),
      .rst      (rst),
      .load     (timer_load),
      .load_val (timer_val),
      .dec      (state != IDLE),
      .done     (timer_done)
   );

   // FSM state, command latch, address cache and registered bus outputs.
   always_ff @(posedge osc) begin
      if (rst) begin
         state            <= IDLE;
         addr_q           <= '0;
         wdata_q          <= '0;
         write_q          <= 1'b0;
         addr_cached      <= '0;
         addr_valid       <= 1'b0;
         flush_pending    <= 1'b0;
         bus.cmd_ready    <= 1'b1;
         bus.rsp_valid    <= 1'b0;
         bus.rsp_data     <= '0;
         bus.bus_ale      <= 1'b0;
         bus.bus_write    <= 1'b0;
         bus.bus_read     <= 1'b1;
         bus.bus_data_out <= '0;
         bus.bus_data_oe  <= 1'b0;
      end else begin
         state <= next_state;

         if (accept) begin
            addr_q  <= bus.cmd_addr;
            wdata_q <= bus.cmd_wdata;
            write_q <= bus.cmd_write;
         end

         // Address cache: a flush in IDLE takes effect now; one seen mid-command
         // is remembered and applied at command end, after any ALE_LO update.
         if (state == IDLE) begin
            if (bus.cache_flush) addr_valid <= 1'b0;
            flush_pending <= 1'b0;
         end else begin
            if (bus.cache_flush) flush_pending <= 1'b1;
            if ((state == ALE_LO) && timer_done) begin
               addr_cached <= addr_q;
               addr_valid  <= 1'b1;
            end
            if ((next_state == IDLE) && (flush_pending || bus.cache_flush)) begin
               addr_valid    <= 1'b0;
               flush_pending <= 1'b0;
            end
         end

         // Outputs are decoded from the phase being entered, so they line up with it.
         bus.cmd_ready <= (next_state == IDLE);
         bus.bus_ale   <= (next_state == ALE_HI);
         bus.bus_write <= (next_state == WR_HI);
         bus.bus_read  <= (next_state != RD_LO);

         case (next_state)
            ALE_HI, ALE_LO: begin
               bus.bus_data_oe  <= 1'b1;
               bus.bus_data_out <= cur_addr;
            end
            WR_SETUP, WR_HI, WR_LO: begin
               bus.bus_data_oe  <= 1'b1;
               bus.bus_data_out <= cur_wdata;
            end
            default: bus.bus_data_oe <= 1'b0;
         endcase

         // Read data is sampled on the last RD_LO cycle and presented for one cycle.
         bus.rsp_valid <= 1'b0;
         if ((state == RD_LO) && (next_state == RD_HI)) begin
            bus.rsp_valid <= 1'b1;
            bus.rsp_data  <= bus.bus_data_in;
         end
      end
   end

endmodule
